// File: rtl/axilite_regfile.sv
// ---------------------------------------------------------------------------
// axilite_regfile
//
// AXI4-Lite slave register bank. AW and W are accepted independently (either
// order or together), a write commits one cycle after the last of the two
// handshakes, and B/R responses are held until the master accepts them.
// Out-of-range word indices answer SLVERR and never touch the register array.
//
// Optional feature macro: AXILITE_REGFILE_WSTRB_EN
//   defined   - only byte lanes with WSTRB[i]=1 are written
//   undefined - WSTRB is ignored and the full word is written
//
// Ports:
//   clk, reset              clock (rising edge) and async active-high reset
//   AXI_AW* / AXI_W*        write address / write data channels
//   AXI_B*                  write response channel
//   AXI_AR* / AXI_R*        read address / read data channels
//   reg0_out                live value of register 0 (control word)
// ---------------------------------------------------------------------------
module axilite_regfile #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS         = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
    input  logic [2:0]                      AXI_AWPROT,
    input  logic                            AXI_AWVALID,
    output logic                            AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    input  logic                            AXI_WVALID,
    output logic                            AXI_WREADY,
    output logic [1:0]                      AXI_BRESP,
    output logic                            AXI_BVALID,
    input  logic                            AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
    input  logic [2:0]                      AXI_ARPROT,
    input  logic                            AXI_ARVALID,
    output logic                            AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    output logic [1:0]                      AXI_RRESP,
    output logic                            AXI_RVALID,
    input  logic                            AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]     reg0_out
);

    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = C_AXI_ADDR_WIDTH - 2;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

    logic [C_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                        ready_en;
    w_state_t                    w_state, w_next;
    r_state_t                    r_state, r_next;
    logic                        aw_hs, w_hs, ar_hs, r_hs;

    logic [IDX_W-1:0]            w_idx;
    logic [C_AXI_DATA_WIDTH-1:0] w_data;
`ifdef AXILITE_REGFILE_WSTRB_EN
    logic [STRB_W-1:0]           w_strb;
`endif
    logic [1:0]                  bresp;
    logic [C_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;

    logic [IDX_W-1:0]            ar_idx;
    logic [RIDX_W-1:0]           w_ridx, ar_ridx;

    // Byte-offset bits and the protection fields carry no meaning here.
    logic unused_inputs;
`ifdef AXILITE_REGFILE_WSTRB_EN
    assign unused_inputs = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};
`else
    assign unused_inputs = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0],
                             AXI_WSTRB};
`endif

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    assign ar_idx  = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
    assign w_ridx  = w_idx[RIDX_W-1:0];
    assign ar_ridx = ar_idx[RIDX_W-1:0];

    assign aw_hs = AXI_AWVALID && AXI_AWREADY;
    assign w_hs  = AXI_WVALID  && AXI_WREADY;
    assign ar_hs = AXI_ARVALID && AXI_ARREADY;
    assign r_hs  = AXI_RVALID  && AXI_RREADY;

    // Holds every ready low while in reset and raises them on the first
    // edge after release.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would make results depend on block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Write FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_next      = w_state;
        AXI_AWREADY = 1'b0;
        AXI_WREADY  = 1'b0;
        AXI_BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                AXI_AWREADY = ready_en;
                AXI_WREADY  = ready_en;
                if (ready_en && AXI_AWVALID && AXI_WVALID) w_next = W_COMMIT;
                else if (ready_en && AXI_AWVALID)          w_next = W_HAVE_ADDR;
                else if (ready_en && AXI_WVALID)           w_next = W_HAVE_DATA;
            end
            W_HAVE_ADDR: begin
                AXI_WREADY = ready_en;
                if (ready_en && AXI_WVALID) w_next = W_COMMIT;
            end
            W_HAVE_DATA: begin
                AXI_AWREADY = ready_en;
                if (ready_en && AXI_AWVALID) w_next = W_COMMIT;
            end
            W_COMMIT: w_next = W_RESP;
            W_RESP: begin
                AXI_BVALID = 1'b1;
                if (AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Capture, commit and write response. The register array lives here
    // only, so the read side sees pre-commit contents on the commit edge.
    // NOTE: the register array is reset explicitly because software relies
    // on every control/status register reading 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_idx  <= '0;
            w_data <= '0;
`ifdef AXILITE_REGFILE_WSTRB_EN
            w_strb <= '0;
`endif
            bresp  <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (aw_hs) w_idx <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data <= AXI_WDATA;
`ifdef AXILITE_REGFILE_WSTRB_EN
                w_strb <= AXI_WSTRB;
`endif
            end
            if (w_state == W_COMMIT) begin
                if (in_range(w_idx)) begin
                    bresp <= RESP_OKAY;
`ifdef AXILITE_REGFILE_WSTRB_EN
                    for (int b = 0; b < STRB_W; b++)
                        if (w_strb[b]) regs[w_ridx][8*b +: 8] <= w_data[8*b +: 8];
`else
                    regs[w_ridx] <= w_data;
`endif
                end else begin
                    bresp <= RESP_SLVERR;
                end
            end
        end
    end

    assign AXI_BRESP = bresp;
    assign reg0_out  = regs[0];

    // -----------------------------------------------------------------------
    // Read FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        AXI_ARREADY = 1'b0;
        AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                AXI_ARREADY = ready_en;
                if (ready_en && AXI_ARVALID) r_next = R_RESP;
            end
            R_RESP: begin
                AXI_RVALID = 1'b1;
                if (AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            if (in_range(ar_idx)) begin
                rdata <= regs[ar_ridx];
                rresp <= RESP_OKAY;
            end else begin
                rdata <= '0;
                rresp <= RESP_SLVERR;
            end
        end else if (r_hs) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end
    end

    assign AXI_RDATA = rdata;
    assign AXI_RRESP = rresp;

endmodule

// File: doc/axilite_regfile.md
Name: axilite_regfile

Overview:
- Fully AXI4-Lite compliant slave register bank; responder to the axilite_int master side driven by master_wrapper.
- Accepts AW and W channels independently, in either order or in the same cycle. Supports byte strobes.
- Returns SLVERR for out-of-range addresses and holds response/read data stable until the master accepts it.
- Replaces the fixed-timing memory slave wherever back-pressure-tolerant peripherals (CPU control/status registers) are attached.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width in bits (multiple of 8)
C_AXI_ADDR_WIDTH, 8, byte address width
NUM_REGS, 16, number of word registers; index = addr[C_AXI_ADDR_WIDTH-1:2]

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
AXI_AWADDR  input  C_AXI_ADDR_WIDTH  write address
AXI_AWPROT  input  3  ignored
AXI_AWVALID  input  1  write address valid
AXI_AWREADY  output  1  write address ready
AXI_WDATA  input  C_AXI_DATA_WIDTH  write data
AXI_WSTRB  input  C_AXI_DATA_WIDTH/8  byte strobes
AXI_WVALID  input  1  write data valid
AXI_WREADY  output  1  write data ready
AXI_BRESP  output  2  write response
AXI_BVALID  output  1  write response valid
AXI_BREADY  input  1  write response ready
AXI_ARADDR  input  C_AXI_ADDR_WIDTH  read address
AXI_ARPROT  input  3  ignored
AXI_ARVALID  input  1  read address valid
AXI_ARREADY  output  1  read address ready
AXI_RDATA  output  C_AXI_DATA_WIDTH  read data
AXI_RRESP  output  2  read response
AXI_RVALID  output  1  read data valid
AXI_RREADY  input  1  read data ready
reg0_out  output  C_AXI_DATA_WIDTH  live value of register 0 (control word)

Behaviour:
- Interface decided: one clock (clk); reset is asynchronous and active-high (reset).
- Reset: all registers 0. AWREADY=WREADY=ARREADY=0 during reset, 1 the cycle after release. BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg0_out=0. Reset mid-transaction aborts it; no partial write, no pending response survives.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
    - AW+W handshake in same cycle -> W_COMMIT.
    - AW only -> capture addr, go W_HAVE_ADDR (AWREADY=0).
    - W only -> capture data+strobe, go W_HAVE_DATA (WREADY=0).
  - W_HAVE_ADDR: WREADY=1; on W handshake -> W_COMMIT.
  - W_HAVE_DATA: AWREADY=1; on AW handshake -> W_COMMIT.
  - W_COMMIT (1 cycle): if index < NUM_REGS, update register per strobes and set BRESP=00; else no write, BRESP=10 (SLVERR). BVALID=1 next cycle -> W_RESP.
  - W_RESP: BVALID and BRESP held until BREADY. On handshake, BVALID=0 -> W_IDLE. AWREADY=WREADY=0 throughout.
  - Latency: last of AW/W handshake to BVALID = 2 cycles.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1. On AR handshake, sample register at that edge into RDATA, set RVALID=1 (1-cycle latency) -> R_RESP. Out-of-range: RDATA=0, RRESP=10.
  - R_RESP: ARREADY=0; RDATA/RRESP/RVALID stable until RREADY. On handshake, RVALID=0, RDATA=0 -> R_IDLE.
- Read and write channels are fully independent and may be active concurrently.
- Same-register collision: a read sampled on the same edge as W_COMMIT returns the old value. A read one cycle later returns the new value.
- Unaligned address bits [1:0] are ignored.
- reg0_out reflects register 0 the cycle after its write commits.

Optional Feature:
AXILITE_REGFILE_WSTRB_EN
- Defined: only byte lanes with WSTRB[i]=1 are written. WSTRB=0 completes with OKAY and changes nothing.
- Undefined: WSTRB is ignored and the full word is always written.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x04 with AW and W in the same cycle, BREADY=1 -> BVALID 2 cycles after handshake, BRESP=00; read 0x04 -> RDATA=0xDEADBEEF one cycle after AR handshake, RRESP=00.
- W issued 3 cycles before AW (data 0x12345678, addr 0x08) -> AWREADY still 1, WREADY 0 while waiting; single BVALID; read 0x08 returns 0x12345678.
- Write addr 0x40 (index 16, NUM_REGS=16) -> BRESP=10, no register changes; read 0x40 -> RDATA=0, RRESP=10.
- RREADY held 0 for 5 cycles after RVALID -> RDATA/RVALID stable, ARREADY=0; released -> RVALID drops next cycle. Repeat for BREADY/BVALID.
- With WSTRB_EN: reg 0x0C=0xFFFFFFFF, write 0x00000000 with WSTRB=0101 -> read 0xFF00FF00. Without WSTRB_EN -> 0x00000000.
- Assert reset while in W_HAVE_ADDR and R_RESP -> RVALID=0 immediately, no register changes; all regs read 0 after release; reg0_out=0.
